// File: rtl/wr_req_credit_arb_pkg.sv
// Shared lynxTypes definitions used by the credit-gated write request arbiter:
// request descriptor, length/beat widths and the ceiling beat-count helper.
package lynxTypes;

    localparam int unsigned AXI_DATA_BITS = 512;
    localparam int unsigned BEAT_LOG_BITS = $clog2(AXI_DATA_BITS / 8);
    localparam int unsigned LEN_BITS      = 28;
    localparam int unsigned BLEN_BITS     = LEN_BITS - BEAT_LOG_BITS;
    localparam int unsigned VADDR_BITS    = 48;
    localparam int unsigned PID_BITS      = 6;

    typedef struct packed {
        logic [VADDR_BITS-1:0] vaddr;
        logic [LEN_BITS-1:0]   len;
        logic [PID_BITS-1:0]   pid;
        logic                  last;
    } req_t;

    // Width of a region index for a given region count
    function automatic int unsigned regions_bits(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Ceiling beat count of a byte length; len = 0 still occupies one beat
    function automatic logic [LEN_BITS:0] beats_ceil(input logic [LEN_BITS-1:0] len,
                                                      input int unsigned       beat_log);
        logic [LEN_BITS:0] one;
        logic [LEN_BITS:0] round;
        logic [LEN_BITS:0] sum;
        one   = (LEN_BITS+1)'(1);
        round = (one << beat_log) - one;
        sum   = {1'b0, len} + round;
        return (len == '0) ? one : (sum >> beat_log);
    endfunction

endpackage

// File: rtl/wr_req_credit_arb_pick.sv
// Combinational round-robin picker: first set bit of an eligible mask searching
// upward from rr_ptr with wrap; reusable by any credit-gated arbiter.
module wr_cred_rr_pick #(
    parameter int unsigned N_REGIONS = 4,
    parameter int unsigned IDX_BITS  = 2
) (
    input  logic [N_REGIONS-1:0] elig,
    input  logic [IDX_BITS-1:0]  rr_ptr,
    output logic [N_REGIONS-1:0] grant,
    output logic [IDX_BITS-1:0]  grant_idx,
    output logic                 grant_vld
);

    logic [IDX_BITS:0]   idx;
    logic [IDX_BITS-1:0] sel;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        idx       = '0;
        sel       = '0;
        for (int unsigned k = 0; k < N_REGIONS; k++) begin
            idx = {1'b0, rr_ptr} + (IDX_BITS+1)'(k);
            if (idx >= (IDX_BITS+1)'(N_REGIONS))
                idx = idx - (IDX_BITS+1)'(N_REGIONS);
            sel = idx[IDX_BITS-1:0];
            if (!grant_vld && elig[sel]) begin
                grant[sel] = 1'b1;
                grant_idx  = sel;
                grant_vld  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wr_req_credit_arb.sv
// Credit-gated round-robin merge of per-region write requests onto one channel.
// Optional per-region grant/stall statistics when WR_ARB_STATS_EN is defined.
module wr_req_credit_arb
    import lynxTypes::*;
#(
    parameter int unsigned N_REGIONS       = 4,
    parameter int unsigned DATA_BITS       = AXI_DATA_BITS,
    parameter int unsigned CRED_BITS       = BLEN_BITS + 1,
    localparam int unsigned N_REGIONS_BITS = regions_bits(N_REGIONS)
) (
    input  logic                      aclk,
    input  logic                      aresetn,

    input  logic [N_REGIONS-1:0]      s_req_valid,
    output logic [N_REGIONS-1:0]      s_req_ready,
    input  req_t                      s_req_data [N_REGIONS],

    output logic                      m_req_valid,
    input  logic                      m_req_ready,
    output req_t                      m_req_data,
    output logic [N_REGIONS_BITS-1:0] m_id,

    input  logic [N_REGIONS-1:0]      xfer,
    output logic [N_REGIONS-1:0]      cred_err
`ifdef WR_ARB_STATS_EN
    ,
    output logic [31:0]               stat_grants [N_REGIONS],
    output logic [31:0]               stat_stall  [N_REGIONS]
`endif
);

    localparam int unsigned BEAT_LOG = $clog2(DATA_BITS / 8);
    localparam int unsigned BW       = LEN_BITS + 1;

    logic [BW-1:0]             n_beats [N_REGIONS];
    logic [CRED_BITS-1:0]      cred    [N_REGIONS];
    logic [N_REGIONS-1:0]      elig;
    logic [N_REGIONS-1:0]      pick_oh;
    logic [N_REGIONS-1:0]      grant;
    logic [N_REGIONS_BITS-1:0] pick_idx;
    logic [N_REGIONS_BITS-1:0] rr_ptr;
    logic                      pick_vld;
    logic                      out_free;
    logic                      grant_en;

    always_comb begin
        n_beats = '{default: '0};
        elig    = '0;
        for (int unsigned i = 0; i < N_REGIONS; i++) begin
            n_beats[i] = beats_ceil(s_req_data[i].len, BEAT_LOG);
            elig[i]    = s_req_valid[i] && (BW'(cred[i]) >= n_beats[i]);
        end
    end

    wr_cred_rr_pick #(
        .N_REGIONS (N_REGIONS),
        .IDX_BITS  (N_REGIONS_BITS)
    ) u_pick (
        .elig      (elig),
        .rr_ptr    (rr_ptr),
        .grant     (pick_oh),
        .grant_idx (pick_idx),
        .grant_vld (pick_vld)
    );

    // Output register accepts a new entry when empty or draining this cycle
    always_comb begin
        out_free    = !m_req_valid || m_req_ready;
        grant_en    = pick_vld && out_free;
        grant       = grant_en ? pick_oh : '0;
        s_req_ready = grant;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rr_ptr <= '0;
        end else if (grant_en) begin
            if (pick_idx == N_REGIONS_BITS'(N_REGIONS - 1))
                rr_ptr <= '0;
            else
                rr_ptr <= pick_idx + N_REGIONS_BITS'(1);
        end
    end

    // Grant never underflows: eligibility already guarantees cred >= n_beats
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int unsigned i = 0; i < N_REGIONS; i++)
                cred[i] <= '0;
            cred_err <= '0;
        end else begin
            for (int unsigned i = 0; i < N_REGIONS; i++) begin
                if (grant[i]) begin
                    cred[i] <= cred[i] - CRED_BITS'(n_beats[i]) + CRED_BITS'(xfer[i]);
                end else if (xfer[i]) begin
                    if (cred[i] == '1)
                        cred_err[i] <= 1'b1;
                    else
                        cred[i] <= cred[i] + CRED_BITS'(1);
                end
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_req_valid <= 1'b0;
            m_req_data  <= '0;
            m_id        <= '0;
        end else if (grant_en) begin
            m_req_valid <= 1'b1;
            m_req_data  <= s_req_data[pick_idx];
            m_id        <= pick_idx;
        end else if (m_req_ready) begin
            m_req_valid <= 1'b0;
        end
    end

`ifdef WR_ARB_STATS_EN
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int unsigned i = 0; i < N_REGIONS; i++) begin
                stat_grants[i] <= '0;
                stat_stall[i]  <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < N_REGIONS; i++) begin
                if (grant[i])
                    stat_grants[i] <= stat_grants[i] + 32'd1;
                if (s_req_valid[i] && !elig[i] && (stat_stall[i] != '1))
                    stat_stall[i] <= stat_stall[i] + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_wr_req_credit_arb.sv
// Directed-vector bench for wr_req_credit_arb: 4 regions, 512-bit data, 4-bit credits.
module tb_wr_req_credit_arb;
    import lynxTypes::*;

    logic       aclk = 1'b0;
    logic       aresetn;
    logic [3:0] s_req_valid;
    logic [3:0] s_req_ready;
    req_t       s_req_data [4];
    logic       m_req_valid;
    logic       m_req_ready;
    req_t       m_req_data;
    logic [1:0] m_id;
    logic [3:0] xfer;
    logic [3:0] cred_err;
`ifdef WR_ARB_STATS_EN
    logic [31:0] stat_grants [4];
    logic [31:0] stat_stall  [4];
`endif

    int unsigned n_vec;
    int unsigned n_err;
    int unsigned exp_ids [5] = '{0, 1, 2, 3, 0};

    always #5 aclk = ~aclk;

    wr_req_credit_arb #(
        .N_REGIONS (4),
        .DATA_BITS (512),
        .CRED_BITS (4)
    ) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .s_req_valid (s_req_valid),
        .s_req_ready (s_req_ready),
        .s_req_data  (s_req_data),
        .m_req_valid (m_req_valid),
        .m_req_ready (m_req_ready),
        .m_req_data  (m_req_data),
        .m_id        (m_id),
        .xfer        (xfer),
        .cred_err    (cred_err)
`ifdef WR_ARB_STATS_EN
        ,
        .stat_grants (stat_grants),
        .stat_stall  (stat_stall)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_reset();
        s_req_valid = '0;
        xfer        = '0;
        m_req_ready = 1'b1;
        aresetn     = 1'b0;
        #1;
        tick();
        aresetn = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        for (int i = 0; i < 4; i++) begin
            s_req_data[i]       = '0;
            s_req_data[i].vaddr = 48'h1000 * (i + 1);
            s_req_data[i].pid   = 6'(i + 1);
        end

        // Reset state
        do_reset();
        #1;
        check("rst_mvalid", 32'(m_req_valid), 32'd0);
        check("rst_mid",    32'(m_id),        32'd0);
        check("rst_ready",  32'(s_req_ready), 32'd0);
        check("rst_err",    32'(cred_err),    32'd0);
        check("rst_rrptr",  32'(dut.rr_ptr),  32'd0);
        tick();

        // 256 B = 4 beats: three credits insufficient, fourth enables grant
        s_req_data[0].len = 28'd256;
        s_req_valid = 4'b0001;
        xfer        = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            #1 check("t1_noready", 32'(s_req_ready), 32'd0);
            tick();
        end
        xfer = '0;
        #1 check("t1_ready", 32'(s_req_ready), 32'b0001);
        tick();
        s_req_valid = '0;
        #1;
        check("t1_mvalid", 32'(m_req_valid),    32'd1);
        check("t1_mid",    32'(m_id),           32'd0);
        check("t1_mlen",   32'(m_req_data.len), 32'd256);
        check("t1_cred0",  32'(dut.cred[0]),    32'd0);
        tick();
        #1 check("t1_drain", 32'(m_req_valid), 32'd0);

        // All regions valid with ample credit: 0,1,2,3,0 back-to-back
        do_reset();
        for (int i = 0; i < 4; i++) s_req_data[i].len = 28'd64;
        xfer = 4'b1111;
        repeat (8) tick();
        xfer        = '0;
        s_req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #1 check("t2_ready", 32'(s_req_ready), 32'(1 << exp_ids[k]));
            if (k > 0) begin
                check("t2_mvalid", 32'(m_req_valid), 32'd1);
                check("t2_mid",    32'(m_id),        exp_ids[k-1]);
            end
            tick();
        end
        s_req_valid = '0;
        #1;
        check("t2_last_mid", 32'(m_id),         32'd0);
        check("t2_cred0",    32'(dut.cred[0]),  32'd6);
        check("t2_cred3",    32'(dut.cred[3]),  32'd7);
        tick();
        #1 check("t2_drain", 32'(m_req_valid), 32'd0);

        // Starved region 0 skipped, region 2 granted at once
        do_reset();
        s_req_data[0].len = 28'd64;
        s_req_data[2].len = 28'd128;
        xfer = 4'b0100;
        repeat (2) tick();
        xfer        = '0;
        s_req_valid = 4'b0101;
        #1 check("t3_skip", 32'(s_req_ready), 32'b0100);
        tick();
        s_req_valid = 4'b0001;
        xfer        = 4'b0001;
        #1;
        check("t3_mid2",    32'(m_id),         32'd2);
        check("t3_rrptr",   32'(dut.rr_ptr),   32'd3);
        check("t3_cred2",   32'(dut.cred[2]),  32'd0);
        check("t3_visible", 32'(s_req_ready),  32'd0);
        tick();
        xfer = '0;
        #1 check("t3_ready0", 32'(s_req_ready), 32'b0001);
        tick();
        s_req_valid = '0;
        #1;
        check("t3_mid0",   32'(m_id),        32'd0);
        check("t3_rrptr1", 32'(dut.rr_ptr),  32'd1);
        tick();

        // Same-cycle grant and xfer: 4 - 4 + 1
        xfer = 4'b0010;
        repeat (4) tick();
        s_req_data[1].len = 28'd256;
        s_req_valid       = 4'b0010;
        #1 check("t4_ready", 32'(s_req_ready), 32'b0010);
        tick();
        s_req_valid = '0;
        xfer        = '0;
        #1;
        check("t4_cred1", 32'(dut.cred[1]), 32'd1);
        check("t4_mid",   32'(m_id),        32'd1);
        tick();

        // Backpressure: one grant then a stable stall; credits still count
        s_req_data[0].len = 28'd64;
        s_req_data[2].len = 28'd60;
        s_req_data[3].len = 28'd1;
        xfer = 4'b1101;
        repeat (4) tick();
        xfer        = '0;
        m_req_ready = 1'b0;
        s_req_valid = 4'b1101;
        #1 check("t5_first", 32'(s_req_ready), 32'b0100);
        tick();
        for (int k = 0; k < 10; k++) begin
            xfer = (k < 3) ? 4'b1000 : 4'b0000;
            #1;
            check("t5_stall_ready", 32'(s_req_ready),    32'd0);
            check("t5_stall_mid",   32'(m_id),           32'd2);
            check("t5_stall_mlen",  32'(m_req_data.len), 32'd60);
            check("t5_stall_valid", 32'(m_req_valid),    32'd1);
            tick();
        end
        xfer = '0;
        check("t5_cred3", 32'(dut.cred[3]), 32'd7);
        m_req_ready = 1'b1;
        #1 check("t5_rel_r3", 32'(s_req_ready), 32'b1000);
        tick();
        #1;
        check("t5_mid3",   32'(m_id),        32'd3);
        check("t5_rel_r0", 32'(s_req_ready), 32'b0001);
        tick();
        #1;
        check("t5_mid0",   32'(m_id),        32'd0);
        check("t5_rel_r2", 32'(s_req_ready), 32'b0100);
        tick();
        s_req_valid = '0;
        #1;
        check("t5_mid2b", 32'(m_id),           32'd2);
        check("t5_mlen2", 32'(m_req_data.len), 32'd60);
        tick();

        // Credit saturation and sticky overflow flag
        do_reset();
        xfer = 4'b0010;
        repeat (15) tick();
        check("t6_cred15", 32'(dut.cred[1]), 32'd15);
        check("t6_noerr",  32'(cred_err),    32'd0);
        tick();
        xfer = '0;
        #1;
        check("t6_sat",  32'(dut.cred[1]), 32'd15);
        check("t6_err",  32'(cred_err),    32'b0010);
        repeat (2) tick();
        check("t6_sticky", 32'(cred_err), 32'b0010);

        // Asynchronous reset with an entry held in the output stage
        s_req_data[1].len = 28'd64;
        s_req_valid       = 4'b0010;
        m_req_ready       = 1'b0;
        #1 check("t6_ready", 32'(s_req_ready), 32'b0010);
        tick();
        s_req_valid = '0;
        xfer        = 4'b0010;
        #1;
        check("t6_held_valid", 32'(m_req_valid), 32'd1);
        check("t6_held_mid",   32'(m_id),        32'd1);
        #2 aresetn = 1'b0;
        #1;
        check("t6_arst_mvalid", 32'(m_req_valid),   32'd0);
        check("t6_arst_mid",    32'(m_id),          32'd0);
        check("t6_arst_err",    32'(cred_err),      32'd0);
        check("t6_arst_ready",  32'(s_req_ready),   32'd0);
        check("t6_arst_cred1",  32'(dut.cred[1]),   32'd0);
        check("t6_arst_rrptr",  32'(dut.rr_ptr),    32'd0);
        xfer = '0;
        tick();
        aresetn = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/wr_req_credit_arb.md
# wr_req_credit_arb

Credit-gated round-robin arbiter that merges write requests from N_REGIONS vFPGA regions onto one shared host/card write request channel. Each region owns a credit counter of write-data beats already queued for it. A region's request is granted only when its queued data fully covers the request. A region with insufficient data is therefore skipped rather than stalling the shared channel.

## Interface
Parameters:
- N_REGIONS, 4, number of requesting regions (2..16)
- DATA_BITS, AXI_DATA_BITS, write data bus width; beat size = DATA_BITS/8 bytes
- CRED_BITS, BLEN_BITS+1, width of each per-region credit counter

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- s_req[N_REGIONS]  metaIntf.s  req_t  per-region write requests (valid/ready/data)
- m_req  metaIntf.m  req_t  merged write request
- m_id  out  N_REGIONS_BITS  region index of the request on m_req; valid with m_req.valid
- xfer[N_REGIONS]  in  1 each  one write-data beat of region i entered its data queue this cycle
- cred_err[N_REGIONS]  out  1 each  sticky credit-overflow flag

## Operation
- Beat count: n_beats = (len + DATA_BITS/8 − 1) >> BEAT_LOG_BITS (ceiling). len = 0 counts as 1 beat. Widen the computation to LEN_BITS+1 before the shift.
- Eligibility: region i is eligible when s_req[i].valid and cred[i] >= n_beats[i].
- Pick: round-robin among eligible regions, starting the search at rr_ptr.
  - On a grant to region g: rr_ptr <= (g+1) mod N_REGIONS.
  - With no grant, rr_ptr holds.
  - Ineligible regions are skipped. There is no head-of-line blocking across regions.
- Grant: at most one per cycle, and only when the output stage is empty or is being drained this cycle (m_req.valid && m_req.ready).
  - On a grant, s_req[g].ready = 1 for that cycle. All other s_req[i].ready = 0.
  - s_req[].ready never depends on a region's own valid beyond eligibility.
- Credit update per region each cycle: cred_next = cred + xfer[i] − (granted_i ? n_beats : 0).
  - Grant and xfer in the same cycle net out: cred − n_beats + 1.
- Overflow: if cred = 2^CRED_BITS−1 and xfer[i] arrives without a grant:
  - cred holds at the maximum;
  - cred_err[i] sets and stays set until reset.
- Underflow is impossible by construction, because a grant requires cred >= n_beats.
- Output stage: a single register holding the req_t and m_id, plus a valid bit.
  - The register loads on a grant.
  - valid clears on a handshake with no new grant.
  - m_req.data and m_id are stable while m_req.valid && !m_req.ready.

## Timing
- Reset values: m_req.valid = 0, m_id = 0, all s_req[].ready = 0, all cred = 0, rr_ptr = 0, all cred_err = 0. Reset takes effect immediately (asynchronous).
- Reset mid-operation: any in-flight output entry is discarded and all credits are lost. Upstream regions are reset in the same domain.
- Latency: grant in cycle t → m_req.valid in cycle t+1.
  - Throughput is 1 request/cycle while m_req.ready = 1.
- Credit visibility: an xfer in cycle t can enable a grant at the earliest in cycle t+1.
- Backpressure: with m_req.ready = 0 and output full, no grants occur. Credits still accumulate.
- The combinational path from s_req.valid to s_req.ready goes through the picker only. No path exists from m_req.ready to m_req.valid.

## Configuration
- WR_ARB_STATS_EN defined:
  - adds output stat_grants[N_REGIONS], 32 bits each: a wrapping grant counter per region, reset to 0;
  - adds output stat_stall[N_REGIONS], 32 bits each: counts cycles where s_req[i].valid && !eligible; saturates at all-ones.
- Undefined: neither port nor any counter logic exists. Behaviour is otherwise identical.

## Structure
- Shared package lynxTypes:
  - reuses req_t, LEN_BITS, BLEN_BITS, BEAT_LOG_BITS;
  - adds N_REGIONS_BITS = clog2(N_REGIONS) and a function for the ceiling beat count.
- Sub-module wr_cred_rr_pick: purely combinational. Inputs are an eligible mask and rr_ptr; outputs are a one-hot grant and its index. It is reused by any future credit-gated arbiter.

## Test plan
- Single region 0, len = 256 B, DATA_BITS = 512 (4 beats), 3 xfer pulses: no grant. The 4th xfer → grant on the next cycle, m_req.valid one cycle later with m_id = 0, cred[0] = 0.
- Regions 0–3 all valid with ample credit and m_req.ready = 1: grants in order 0,1,2,3,0. One m_req per cycle with no bubbles.
- Region 0 valid with cred 0, region 2 valid with sufficient credit: region 2 granted immediately. Region 0 is not granted until credited, and rr_ptr advances past 2.
- Same-cycle grant and xfer with cred = 4 and n_beats = 4: cred = 1 afterwards.
- m_req.ready held low for 10 cycles with 3 regions valid: exactly one grant, m_req.data/m_id stable throughout. On release, grants resume at 1/cycle.
- With CRED_BITS = 4, 16 xfers to region 1 with no request: cred[1] = 15 and cred_err[1] = 1, which stays set. Assert aresetn mid-burst → all outputs at reset values within the same cycle.
